// File: rtl/lsu_if.sv
// lsu_if: pipeline-side and data-memory-side signals of the load/store unit.
//   Pipeline : in_valid/in_ready handshake, in_we, in_funct3, in_addr, in_wdata;
//              out_valid pulse with out_rdata/out_err.
//   Memory   : dmem_req/dmem_gnt request handshake, dmem_we, dmem_addr,
//              dmem_wstrb, dmem_wdata; dmem_rvalid/dmem_rdata response.
// slave  = the LSU side, master = pipeline + memory side (drivers of the LSU).
interface lsu_if #(
    parameter int DATAW = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             in_we;
    logic [2:0]       in_funct3;
    logic [DATAW-1:0] in_addr;
    logic [DATAW-1:0] in_wdata;
    logic             out_valid;
    logic [DATAW-1:0] out_rdata;
    logic             out_err;
    logic             dmem_req;
    logic             dmem_we;
    logic [DATAW-1:0] dmem_addr;
    logic [3:0]       dmem_wstrb;
    logic [DATAW-1:0] dmem_wdata;
    logic             dmem_gnt;
    logic             dmem_rvalid;
    logic [DATAW-1:0] dmem_rdata;

    modport slave (
        input  in_valid, in_we, in_funct3, in_addr, in_wdata,
               dmem_gnt, dmem_rvalid, dmem_rdata,
        output in_ready, out_valid, out_rdata, out_err,
               dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata
    );

    modport master (
        output in_valid, in_we, in_funct3, in_addr, in_wdata,
               dmem_gnt, dmem_rvalid, dmem_rdata,
        input  in_ready, out_valid, out_rdata, out_err,
               dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata
    );
endinterface

// File: rtl/lsu.sv
// lsu: RV32I load/store unit for the MEM stage.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - lsu_if.slave: pipeline valid/ready op in, one-cycle completion
//           pulse out; data-memory req/gnt request and rvalid response.
// One op in flight at a time: IDLE -> REQ -> RESP -> DONE -> IDLE, or
// IDLE -> DONE directly for misaligned/illegal ops (no memory access).
// All outputs except in_ready are registered; in_ready is a decode of state.
module lsu #(
    parameter int DATAW = 32
) (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

    state_e           state_q, state_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic             req_q, req_d;
    logic             dwe_q, dwe_d;
    logic [DATAW-1:0] daddr_q, daddr_d;
    logic [3:0]       strb_q, strb_d;
    logic [DATAW-1:0] dwdata_q, dwdata_d;
    logic             ovalid_q, ovalid_d;
    logic             oerr_q, oerr_d;
    logic [DATAW-1:0] ordata_q, ordata_d;

    // Accept-time legality and alignment check on the raw pipeline inputs.
    logic             acc_bad;
    logic [3:0]       st_strb;
    logic [DATAW-1:0] st_wdata;

    always_comb begin
        logic illegal, misal;
        if (bus.in_we)
            illegal = !(bus.in_funct3 inside {3'b000, 3'b001, 3'b010});
        else
            illegal = bus.in_funct3 inside {3'b011, 3'b110, 3'b111};
        misal = ((bus.in_funct3[1:0] == 2'b01) && bus.in_addr[0]) ||
                ((bus.in_funct3[1:0] == 2'b10) && (bus.in_addr[1:0] != 2'b00));
        acc_bad = illegal || misal;
    end

    // Store lanes: data is replicated so the strobes alone pick the lane.
    always_comb begin
        case (bus.in_funct3[1:0])
            2'b00: begin
                st_strb  = 4'b0001 << bus.in_addr[1:0];
                st_wdata = {4{bus.in_wdata[7:0]}};
            end
            2'b01: begin
                st_strb  = bus.in_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{bus.in_wdata[15:0]}};
            end
            default: begin
                st_strb  = 4'b1111;
                st_wdata = bus.in_wdata;
            end
        endcase
    end

    // Load extraction from the returned word using the latched offset/funct3.
    logic [DATAW-1:0] ld_data;
    always_comb begin
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        lane_b = bus.dmem_rdata[8*off_q +: 8];
        lane_h = off_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{(DATAW-8){lane_b[7]}}, lane_b};
            3'b100:  ld_data = {{(DATAW-8){1'b0}}, lane_b};
            3'b001:  ld_data = {{(DATAW-16){lane_h[15]}}, lane_h};
            3'b101:  ld_data = {{(DATAW-16){1'b0}}, lane_h};
            default: ld_data = bus.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        f3_d     = f3_q;
        off_d    = off_q;
        req_d    = req_q;
        dwe_d    = dwe_q;
        daddr_d  = daddr_q;
        strb_d   = strb_q;
        dwdata_d = dwdata_q;
        ovalid_d = 1'b0;
        oerr_d   = oerr_q;
        ordata_d = ordata_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    we_d  = bus.in_we;
                    f3_d  = bus.in_funct3;
                    off_d = bus.in_addr[1:0];
                    if (acc_bad) begin
                        state_d  = DONE;
                        ovalid_d = 1'b1;
                        oerr_d   = 1'b1;
                        ordata_d = '0;
                    end else begin
                        state_d  = REQ;
                        req_d    = 1'b1;
                        dwe_d    = bus.in_we;
                        daddr_d  = {bus.in_addr[DATAW-1:2], 2'b00};
                        strb_d   = bus.in_we ? st_strb : 4'b0000;
                        dwdata_d = bus.in_we ? st_wdata : '0;
                    end
                end
            end
            REQ: begin
                // rvalid in the gnt cycle belongs to nothing we issued; ignore it.
                if (bus.dmem_gnt) begin
                    state_d  = RESP;
                    req_d    = 1'b0;
                    dwe_d    = 1'b0;
                    daddr_d  = '0;
                    strb_d   = 4'b0000;
                    dwdata_d = '0;
                end
            end
            RESP: begin
                if (bus.dmem_rvalid) begin
                    state_d  = DONE;
                    ovalid_d = 1'b1;
                    oerr_d   = 1'b0;
                    ordata_d = we_q ? '0 : ld_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            off_q    <= 2'b00;
            req_q    <= 1'b0;
            dwe_q    <= 1'b0;
            daddr_q  <= '0;
            strb_q   <= 4'b0000;
            dwdata_q <= '0;
            ovalid_q <= 1'b0;
            oerr_q   <= 1'b0;
            ordata_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            req_q    <= req_d;
            dwe_q    <= dwe_d;
            daddr_q  <= daddr_d;
            strb_q   <= strb_d;
            dwdata_q <= dwdata_d;
            ovalid_q <= ovalid_d;
            oerr_q   <= oerr_d;
            ordata_q <= ordata_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = ovalid_q;
    assign bus.out_err    = oerr_q;
    assign bus.out_rdata  = ordata_q;
    assign bus.dmem_req   = req_q;
    assign bus.dmem_we    = dwe_q;
    assign bus.dmem_addr  = daddr_q;
    assign bus.dmem_wstrb = strb_q;
    assign bus.dmem_wdata = dwdata_q;
endmodule
